// File: rtl/vip_pkg.sv
// Shared definitions for the VIP frame controllers: pixel/counter widths and
// the frame-tracking state encoding.
package vip_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned CNT_W = 11;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/vip_sync_edge.sv
// Registers vsync/href and derives their edge pulses from the registered copy.
module vip_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    input  logic href,
    output logic vsync_q,
    output logic href_q,
    output logic vsync_rise_c,
    output logic vsync_fall_c,
    output logic href_fall_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
        end
    end

    assign vsync_rise_c = vsync & ~vsync_q;
    assign vsync_fall_c = ~vsync & vsync_q;
    assign href_fall_c  = ~href & href_q;

endmodule

// File: rtl/vip_median_frame_ctrl.sv
// Frame controller behind the 3x3 median stage: frame-boundary config, border
// substitution with raw pixels, frame completion and geometry error reporting.
module vip_median_frame_ctrl
    import vip_pkg::*;
#(
    parameter logic [CNT_W-1:0] IMG_HDISP = 11'd800,
    parameter logic [CNT_W-1:0] IMG_VDISP = 11'd600,
    parameter int unsigned      BORDER    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_filter_en,
    input  logic             cfg_update,
    input  logic             err_clr,
    input  logic             in_vsync,
    input  logic             in_href,
    input  logic             in_clken,
    input  logic [PIX_W-1:0] in_filt_Y,
    input  logic [PIX_W-1:0] in_raw_Y,
    output logic             out_vsync,
    output logic             out_href,
    output logic             out_clken,
    output logic [PIX_W-1:0] out_img_Y,
    output logic             active_en,
    output logic             busy,
    output logic             frame_done,
    output logic             size_err
);

    localparam logic [CNT_W-1:0] B_LO  = CNT_W'(BORDER);
    localparam logic [CNT_W-1:0] H_HI  = IMG_HDISP - CNT_W'(BORDER);
    localparam logic [CNT_W-1:0] V_HI  = IMG_VDISP - CNT_W'(BORDER);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, next_state;
    logic [CNT_W-1:0] col_cnt, row_cnt;
    logic             pending_en, pending_vld, line_err;
    logic             vsync_rise_c, vsync_fall_c, href_fall_c;
    logic             frame_start_c, size_bad_c, border_c;

    vip_sync_edge u_sync_edge (
        .clk          (clk),
        .rst          (rst),
        .vsync        (in_vsync),
        .href         (in_href),
        .vsync_q      (out_vsync),
        .href_q       (out_href),
        .vsync_rise_c (vsync_rise_c),
        .vsync_fall_c (vsync_fall_c),
        .href_fall_c  (href_fall_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SYNC;
        else     state <= next_state;
    end

    // SYNC discards a frame already in progress when reset is released
    always_comb begin
        next_state = state;
        case (state)
            SYNC:    if (!in_vsync)    next_state = IDLE;
            IDLE:    if (vsync_rise_c) next_state = ACTIVE;
            ACTIVE:  if (vsync_fall_c) next_state = DONE;
            DONE:                      next_state = IDLE;
            default:                   next_state = SYNC;
        endcase
    end

    assign frame_start_c = (state == IDLE) && vsync_rise_c;
    assign size_bad_c    = (state == DONE) && ((row_cnt != IMG_VDISP) || line_err);
    assign border_c      = (row_cnt < B_LO) || (row_cnt >= V_HI) ||
                           (col_cnt < B_LO) || (col_cnt >= H_HI);

    // Pixel/line position, counted only inside a tracked frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            line_err <= 1'b0;
        end else if (frame_start_c) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (state == ACTIVE) begin
            if (href_fall_c) begin
                if (col_cnt != IMG_HDISP) line_err <= 1'b1;
                col_cnt <= '0;
                if (row_cnt != CNT_MAX) row_cnt <= row_cnt + CNT_W'(1);
            end else if (in_href && in_clken && (col_cnt != CNT_MAX)) begin
                col_cnt <= col_cnt + CNT_W'(1);
            end
        end else if (state == DONE) begin
            line_err <= 1'b0;
        end
    end

    // A cfg_update coinciding with frame start lands in pending for the next frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_en  <= 1'b0;
            pending_vld <= 1'b0;
            active_en   <= 1'b0;
        end else begin
            if (frame_start_c && pending_vld) begin
                active_en   <= pending_en;
                pending_vld <= 1'b0;
            end
            if (cfg_update) begin
                pending_en  <= cfg_filter_en;
                pending_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_clken  <= 1'b0;
            out_img_Y  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            size_err   <= 1'b0;
        end else begin
            out_clken  <= in_clken;
            out_img_Y  <= !in_clken ? '0 :
                          (active_en && !border_c) ? in_filt_Y : in_raw_Y;
            busy       <= (next_state == ACTIVE);
            frame_done <= (next_state == DONE);
            if (size_bad_c)   size_err <= 1'b1;
            else if (err_clr) size_err <= 1'b0;
        end
    end

endmodule
